// File: rtl/int_multiplier_seq_if.sv
// Operand/result bundle for the sequential multiplier.
// start is accepted only while busy = 0; done is a one-cycle pulse with product/product_sat/overflow valid.
interface int_multiplier_seq_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     product_sat;
  logic                 overflow;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  busy, done, product, product_sat, overflow
  );

  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output busy, done, product, product_sat, overflow
  );
endinterface

// File: rtl/int_multiplier_seq.sv
// Sequential shift-add multiplier: one partial-product step per clock on operand magnitudes,
// sign applied and result saturated as the FSM enters FIN.
module int_multiplier_seq #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  int_multiplier_seq_if.slave    bus,
  output logic [1:0]             state_dbg
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 neg_q, neg_d;
  logic                 sgn_q, sgn_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]     product_sat_q, product_sat_d;
  logic                 overflow_q, overflow_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   res;
  logic                 ovf;
  logic [WIDTH-1:0]     sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      neg_q         <= 1'b0;
      sgn_q         <= 1'b0;
      product_q     <= '0;
      product_sat_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      neg_q         <= neg_d;
      sgn_q         <= sgn_d;
      product_q     <= product_d;
      product_sat_q <= product_sat_d;
      overflow_q    <= overflow_d;
    end
  end

  // Magnitudes fit WIDTH bits unsigned, including |-2^(WIDTH-1)|.
  always_comb begin
    a_mag = bus.multiplicand;
    b_mag = bus.multiplier;
    if (bus.is_signed && bus.multiplicand[WIDTH-1]) a_mag = -bus.multiplicand;
    if (bus.is_signed && bus.multiplier[WIDTH-1])   b_mag = -bus.multiplier;
  end

  always_comb begin
    res = neg_q ? -acc_q : acc_q;
    ovf = 1'b0;
    sat = res[WIDTH-1:0];
    if (sgn_q) begin
      ovf = !((&res[2*WIDTH-1:WIDTH-1]) || !(|res[2*WIDTH-1:WIDTH-1]));
      if (ovf) sat = res[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      ovf = |res[2*WIDTH-1:WIDTH];
      if (ovf) sat = '1;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    neg_d         = neg_q;
    sgn_d         = sgn_q;
    product_d     = product_q;
    product_sat_d = product_sat_q;
    overflow_d    = overflow_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          sgn_d    = bus.is_signed;
          neg_d    = bus.is_signed & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        // Counter values 0..WIDTH-1 are the bit steps; the extra pass commits the result.
        if (cnt_q == CNT_LAST) begin
          state_d       = FIN;
          product_d     = res;
          product_sat_d = sat;
          overflow_d    = ovf;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == FIN);
  assign bus.product     = product_q;
  assign bus.product_sat = product_sat_q;
  assign bus.overflow    = overflow_q;
  assign state_dbg       = state_q;
endmodule

// File: tb/tb_int_multiplier_seq.sv
// Directed bench for int_multiplier_seq: hand-computed products, latency, handshake and reset abort.
module tb_int_multiplier_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] state_dbg;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  int_multiplier_seq_if #(.WIDTH(32)) mif ();

  int_multiplier_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (mif.slave),
    .state_dbg (state_dbg)
  );

  task automatic test_reset();
    #2;
    n_checks++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0 || mif.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b done=%b overflow=%b required 0 0 0", mif.busy, mif.done, mif.overflow);
    end
    n_checks++;
    if (mif.product !== 64'd0 || mif.product_sat !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: product=%h sat=%h required 0 0", mif.product, mif.product_sat);
    end
    n_checks++;
    if (state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d required 0", state_dbg);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one operation, scramble the inputs while busy, and check latency, results and the busy drop.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input string name,
                        input logic [63:0] exp_p, input logic [31:0] exp_sat, input logic exp_ov);
    int lat;
    bit seen;
    @(negedge clk);
    mif.start = 1'b1;
    mif.is_signed = s;
    mif.multiplicand = a;
    mif.multiplier = b;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    mif.is_signed = ~s;
    mif.multiplicand = $urandom;
    mif.multiplier = $urandom;
    n_checks++;
    if (mif.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_busy_rise: busy=%b required 1", name, mif.busy);
    end
    lat = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (mif.done === 1'b1) seen = 1;
    end
    n_checks++;
    if (lat !== 33) begin
      n_fail++;
      $display("FAIL %s_latency: done after %0d edges required 33", name, lat);
    end
    n_checks++;
    if (mif.product !== exp_p) begin
      n_fail++;
      $display("FAIL %s_product: got %h required %h", name, mif.product, exp_p);
    end
    n_checks++;
    if (mif.product_sat !== exp_sat || mif.overflow !== exp_ov) begin
      n_fail++;
      $display("FAIL %s_sat: got sat=%h ov=%b required sat=%h ov=%b", name, mif.product_sat, mif.overflow, exp_sat, exp_ov);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_end: busy=%b done=%b required 0 0", name, mif.busy, mif.done);
    end
  endtask

  task automatic test_unsigned();
    run_op(32'd7, 32'd6, 1'b0, "u_7x6", 64'h0000_0000_0000_002A, 32'h0000_002A, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_max", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1'b1);
    run_op(32'h7FFF_FFFF, 32'd2, 1'b0, "u_fit", 64'h0000_0000_FFFF_FFFE, 32'hFFFF_FFFE, 1'b0);
  endtask

  task automatic test_signed();
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, "s_m3x5", 64'hFFFF_FFFF_FFFF_FFF1, 32'hFFFF_FFF1, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, "s_minxmin", 64'h4000_0000_0000_0000, 32'h7FFF_FFFF, 1'b1);
    run_op(32'h8000_0000, 32'd1, 1'b1, "s_minx1", 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 1'b0);
    run_op(32'h7FFF_FFFF, 32'd2, 1'b1, "s_posovf", 64'h0000_0000_FFFF_FFFE, 32'h7FFF_FFFF, 1'b1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "s_m1xm1", 64'h0000_0000_0000_0001, 32'h0000_0001, 1'b0);
  endtask

  task automatic test_zero_operand();
    run_op(32'hFFFF_FFFB, 32'd0, 1'b1, "s_zero", 64'd0, 32'd0, 1'b0);
  endtask

  task automatic test_output_hold();
    run_op(32'd12, 32'd11, 1'b0, "hold", 64'd132, 32'd132, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (mif.product !== 64'd132 || mif.product_sat !== 32'd132 || mif.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_idle: product=%h sat=%h ov=%b required 84 84 0", mif.product, mif.product_sat, mif.overflow);
    end
  endtask

  task automatic test_back_to_back();
    int done_cnt;
    int done_cyc;
    logic [63:0] got_p;
    logic busy34;
    done_cnt = 0;
    done_cyc = -1;
    got_p = '0;
    busy34 = 1'bx;
    @(negedge clk);
    mif.start = 1'b1;
    mif.is_signed = 1'b0;
    mif.multiplicand = 32'd100;
    mif.multiplier = 32'd3;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 5 || cyc == 33) begin
        mif.start = 1'b1;
        mif.multiplicand = 32'd9;
        mif.multiplier = 32'd9;
      end else begin
        mif.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (mif.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        got_p = mif.product;
      end
      if (cyc == 34) busy34 = mif.busy;
    end
    n_checks++;
    if (done_cnt !== 1 || done_cyc !== 33) begin
      n_fail++;
      $display("FAIL b2b_done: count=%0d at edge %0d required 1 at edge 33", done_cnt, done_cyc);
    end
    n_checks++;
    if (got_p !== 64'd300) begin
      n_fail++;
      $display("FAIL b2b_product: got %0d required 300", got_p);
    end
    n_checks++;
    if (busy34 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_busy34: busy=%b required 0", busy34);
    end
  endtask

  task automatic test_reset_abort();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    mif.start = 1'b1;
    mif.is_signed = 1'b0;
    mif.multiplicand = 32'd100;
    mif.multiplier = 32'd3;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL abort_flags: busy=%b done=%b state=%0d required 0 0 0", mif.busy, mif.done, state_dbg);
    end
    n_checks++;
    if (mif.product !== 64'd0 || mif.product_sat !== 32'd0 || mif.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: product=%h sat=%h ov=%b required 0 0 0", mif.product, mif.product_sat, mif.overflow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (mif.done === 1'b1) done_seen++;
    end
    n_checks++;
    if (done_seen !== 0 || mif.product !== 64'd0) begin
      n_fail++;
      $display("FAIL abort_no_done: done pulses=%0d product=%h required 0 0", done_seen, mif.product);
    end
  endtask

  initial begin
    mif.start = 1'b0;
    mif.is_signed = 1'b0;
    mif.multiplicand = '0;
    mif.multiplier = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_zero_operand();
    test_output_hold();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
